// File: rtl/entity_draw.sv
// entity_draw: walks a table of entities in memory and plots each one through
// the shared datapath handshake (MEMREAD x, MEMREAD y, DRAW). Supports an
// erase mode (redraw in the erase colour) and clips off-screen entities.
module entity_draw #(
  parameter int                 MAX_COUNT         = 16,
  parameter int                 CNT_W             = 5,
  parameter int                 ADDR_STRIDE       = 1,
  parameter logic [2:0]         DRAW_COLOUR       = 3'b100,
  parameter logic [2:0]         ERASE_COLOUR      = 3'b000,
  parameter int                 SCREEN_W          = 160,
  parameter int                 SCREEN_H          = 120,
  parameter int                 MEM_ADDR_WIDTH    = 8,
  parameter int                 RESULT_WIDTH      = 16,
  parameter int                 INSTRUCTION_WIDTH = 32,
  parameter int                 X_COORD_WIDTH     = 8,
  parameter int                 Y_COORD_WIDTH     = 7,
  parameter int                 OPCODE_W          = 4,
  parameter logic [OPCODE_W-1:0] OPCODE_MEMREAD   = 4'h1,
  parameter logic [OPCODE_W-1:0] OPCODE_DRAW      = 4'h2
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         start,
  output logic                         finished,
  input  logic                         erase,
  input  logic [CNT_W-1:0]             count,
  input  logic [MEM_ADDR_WIDTH-1:0]    x_base,
  input  logic [MEM_ADDR_WIDTH-1:0]    y_base,
  input  logic                         finished_dp,
  input  logic [RESULT_WIDTH-1:0]      result_dp,
  output logic                         start_dp,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_dp,
  output logic [CNT_W-1:0]             drawn_count
);

  localparam int RD_PAD = INSTRUCTION_WIDTH - OPCODE_W - MEM_ADDR_WIDTH;
  localparam int DR_PAD = INSTRUCTION_WIDTH - OPCODE_W - 1 - 3 - Y_COORD_WIDTH - X_COORD_WIDTH;

  typedef enum logic [3:0] {
    S_IDLE, S_RX_ISSUE, S_RX_HOLD, S_RX_WAIT,
    S_RY_ISSUE, S_RY_HOLD, S_RY_WAIT, S_CLIP,
    S_DR_ISSUE, S_DR_HOLD, S_DR_WAIT, S_NEXT
  } state_t;

  state_t                     state;
  logic                       erase_q;
  logic [CNT_W-1:0]           count_q;
  logic [CNT_W-1:0]           index_q;
  logic [MEM_ADDR_WIDTH-1:0]  addr_x_q;
  logic [MEM_ADDR_WIDTH-1:0]  addr_y_q;
  logic [X_COORD_WIDTH-1:0]   x_q;
  logic [Y_COORD_WIDTH-1:0]   y_q;

  logic [CNT_W-1:0]           count_clamped;
  logic [CNT_W-1:0]           next_index;
  logic [MEM_ADDR_WIDTH-1:0]  next_addr_x;
  logic [MEM_ADDR_WIDTH-1:0]  next_addr_y;
  logic [2:0]                 colour;
  logic                       off_screen;
  logic                       unused_result_bits;

  function automatic logic [INSTRUCTION_WIDTH-1:0] memread_instr(
    input logic [MEM_ADDR_WIDTH-1:0] addr);
    return {OPCODE_MEMREAD, {RD_PAD{1'b0}}, addr};
  endfunction

  function automatic logic [INSTRUCTION_WIDTH-1:0] draw_instr(
    input logic [2:0]               col,
    input logic [Y_COORD_WIDTH-1:0] yc,
    input logic [X_COORD_WIDTH-1:0] xc);
    return {OPCODE_DRAW, {DR_PAD{1'b0}}, 1'b1, col, yc, xc};
  endfunction

  // Requests larger than the table size are silently limited to MAX_COUNT.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
    return (c > CNT_W'(MAX_COUNT)) ? CNT_W'(MAX_COUNT) : c;
  endfunction

  assign count_clamped      = clamp_count(count);
  assign next_index         = index_q + CNT_W'(1);
  // Running addresses wrap naturally at the memory address width.
  assign next_addr_x        = addr_x_q + MEM_ADDR_WIDTH'(ADDR_STRIDE);
  assign next_addr_y        = addr_y_q + MEM_ADDR_WIDTH'(ADDR_STRIDE);
  assign colour             = erase_q ? ERASE_COLOUR : DRAW_COLOUR;
  assign off_screen         = (32'(x_q) >= SCREEN_W) || (32'(y_q) >= SCREEN_H);
  assign unused_result_bits = ^result_dp[RESULT_WIDTH-1:X_COORD_WIDTH];

  // Sequencer: every output is registered; start_dp and instruction_dp are set
  // on the edge entering an ISSUE state so they are valid during ISSUE and HOLD.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state          <= S_IDLE;
      finished       <= 1'b1;
      start_dp       <= 1'b0;
      instruction_dp <= '0;
      drawn_count    <= '0;
      erase_q        <= 1'b0;
      count_q        <= '0;
      index_q        <= '0;
      addr_x_q       <= '0;
      addr_y_q       <= '0;
      x_q            <= '0;
      y_q            <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            erase_q     <= erase;
            count_q     <= count_clamped;
            addr_x_q    <= x_base;
            addr_y_q    <= y_base;
            index_q     <= '0;
            drawn_count <= '0;
            finished    <= 1'b0;
            if (count_clamped == '0) begin
              state <= S_NEXT;
            end else begin
              start_dp       <= 1'b1;
              instruction_dp <= memread_instr(x_base);
              state          <= S_RX_ISSUE;
            end
          end else begin
            // finished rises one cycle after IDLE is reached.
            finished <= 1'b1;
          end
        end
        S_RX_ISSUE: state <= S_RX_HOLD;
        S_RX_HOLD: begin
          start_dp <= 1'b0;
          state    <= S_RX_WAIT;
        end
        S_RX_WAIT: begin
          if (finished_dp) begin
            x_q            <= result_dp[X_COORD_WIDTH-1:0];
            start_dp       <= 1'b1;
            instruction_dp <= memread_instr(addr_y_q);
            state          <= S_RY_ISSUE;
          end
        end
        S_RY_ISSUE: state <= S_RY_HOLD;
        S_RY_HOLD: begin
          start_dp <= 1'b0;
          state    <= S_RY_WAIT;
        end
        S_RY_WAIT: begin
          if (finished_dp) begin
            y_q   <= result_dp[Y_COORD_WIDTH-1:0];
            state <= S_CLIP;
          end
        end
        S_CLIP: begin
          if (off_screen) begin
            state <= S_NEXT;
          end else begin
            start_dp       <= 1'b1;
            instruction_dp <= draw_instr(colour, y_q, x_q);
            state          <= S_DR_ISSUE;
          end
        end
        S_DR_ISSUE: state <= S_DR_HOLD;
        S_DR_HOLD: begin
          start_dp <= 1'b0;
          state    <= S_DR_WAIT;
        end
        S_DR_WAIT: begin
          if (finished_dp) begin
            drawn_count <= drawn_count + CNT_W'(1);
            state       <= S_NEXT;
          end
        end
        S_NEXT: begin
          index_q <= next_index;
          // >= also covers the empty run, where count_q is zero.
          if (next_index >= count_q) begin
            state <= S_IDLE;
          end else begin
            addr_x_q       <= next_addr_x;
            addr_y_q       <= next_addr_y;
            start_dp       <= 1'b1;
            instruction_dp <= memread_instr(next_addr_x);
            state          <= S_RX_ISSUE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_entity_draw.sv
// Testbench for entity_draw: a behavioural datapath answers each request one
// cycle after HOLD from a small memory; runs are described by a vector table.
module tb_entity_draw;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        finished;
  logic        erase = 1'b0;
  logic [4:0]  count = '0;
  logic [7:0]  x_base = '0;
  logic [7:0]  y_base = '0;
  logic        finished_dp = 1'b0;
  logic [15:0] result_dp = '0;
  logic        start_dp;
  logic [31:0] instruction_dp;
  logic [4:0]  drawn_count;

  entity_draw dut (
    .clock          (clock),
    .resetn         (resetn),
    .start          (start),
    .finished       (finished),
    .erase          (erase),
    .count          (count),
    .x_base         (x_base),
    .y_base         (y_base),
    .finished_dp    (finished_dp),
    .result_dp      (result_dp),
    .start_dp       (start_dp),
    .instruction_dp (instruction_dp),
    .drawn_count    (drawn_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];
  logic [31:0] log_q [$];
  int          bad_pulse = 0;
  logic        prev_sdp = 1'b0;
  int          hi = 0;
  logic        glitch_hold = 1'b0;

  // Datapath model: logs each request, answers one cycle after HOLD.
  always @(negedge clock) begin
    if (!resetn) begin
      prev_sdp    = 1'b0;
      finished_dp = 1'b0;
      hi          = 0;
    end else begin
      finished_dp = 1'b0;
      if (start_dp && !prev_sdp) begin
        log_q.push_back(instruction_dp);
        hi = 1;
      end else if (start_dp && prev_sdp) begin
        hi++;
        if (glitch_hold) finished_dp = 1'b1;
      end else if (!start_dp && prev_sdp) begin
        if (hi != 2) bad_pulse++;
        finished_dp = 1'b1;
        result_dp   = mem[instruction_dp[7:0]];
      end
      prev_sdp = start_dp;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [7:0] a);
    return {4'h1, 20'h0, a};
  endfunction

  function automatic logic [31:0] dr(input logic [2:0] col, input logic [6:0] y, input logic [7:0] x);
    return {4'h2, 9'h0, 1'b1, col, y, x};
  endfunction

  typedef struct {
    logic       erase;
    logic [4:0] count;
    logic [7:0] xb;
    logic [7:0] yb;
    bit         clip;
    bit         glitch;
    int         exp_cyc;
    int         exp_drawn;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input string tag, input vec_t v);
    logic [31:0] exp_q [$];
    int base, pulses0, cyc, n;
    logic [7:0] ax, ay, xv;
    logic [6:0] yv;
    if (v.clip) mem[11] = {8'hA5, 8'd200};
    glitch_hold = v.glitch;
    // expected transaction list from the memory contents
    n = (v.count > 5'd16) ? 16 : int'(v.count);
    for (int i = 0; i < n; i++) begin
      ax = v.xb + 8'(i);
      ay = v.yb + 8'(i);
      exp_q.push_back(rd(ax));
      exp_q.push_back(rd(ay));
      xv = mem[ax][7:0];
      yv = mem[ay][6:0];
      if (xv < 8'd160 && yv < 7'd120)
        exp_q.push_back(dr(v.erase ? 3'b000 : 3'b100, yv, xv));
    end
    base    = log_q.size();
    pulses0 = bad_pulse;
    @(negedge clock);
    erase  = v.erase;
    count  = v.count;
    x_base = v.xb;
    y_base = v.yb;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc   = 0;
    while (!finished && cyc < 3000) begin
      cyc++;
      start = (v.glitch && cyc == 10);
      @(negedge clock);
    end
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk({tag, " cycles"}, 32'(cyc), 32'(v.exp_cyc));
    chk({tag, " drawn_count"}, 32'(drawn_count), 32'(v.exp_drawn));
    chk({tag, " txn_count"}, 32'(log_q.size() - base), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && base + k < log_q.size(); k++)
      chk($sformatf("%s txn%0d", tag, k), log_q[base + k], exp_q[k]);
    chk({tag, " pulse_len"}, 32'(bad_pulse - pulses0), 32'd0);
    chk({tag, " finished"}, 32'(finished), 32'd1);
    if (v.clip) mem[11] = {8'hA5, 8'd11};
    glitch_hold = 1'b0;
  endtask

  initial begin
    int base, w;
    for (int a = 0; a < 256; a++) mem[a] = {8'hA5, 8'(a % 100)};
    mem[10] = {8'hA5, 8'd5};  mem[11] = {8'hA5, 8'd6};  mem[12] = {8'hA5, 8'd7};
    mem[40] = {8'hA5, 8'd8};  mem[41] = {8'hA5, 8'd9};  mem[42] = {8'hA5, 8'd10};
    mem[255] = {8'hA5, 8'd55};

    //          erase count xb     yb     clip glitch cyc drawn
    vecs[0] = '{1'b0, 5'd3,  8'd10,  8'd40,  0, 0, 34,  3};
    vecs[1] = '{1'b1, 5'd3,  8'd10,  8'd40,  0, 0, 34,  3};
    vecs[2] = '{1'b0, 5'd3,  8'd10,  8'd40,  1, 0, 31,  2};
    vecs[3] = '{1'b0, 5'd0,  8'd10,  8'd40,  0, 0, 2,   0};
    vecs[4] = '{1'b0, 5'd31, 8'd100, 8'd150, 0, 0, 177, 16};
    vecs[5] = '{1'b0, 5'd2,  8'd255, 8'd60,  0, 0, 23,  2};
    vecs[6] = '{1'b0, 5'd3,  8'd10,  8'd40,  0, 1, 34,  3};

    #12;
    chk("reset finished", 32'(finished), 32'd1);
    chk("reset start_dp", 32'(start_dp), 32'd0);
    chk("reset instruction_dp", instruction_dp, 32'd0);
    chk("reset drawn_count", 32'(drawn_count), 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    base = log_q.size();
    run_vec("basic", vecs[0]);
    chk("basic first read", log_q[base], 32'h1000000A);
    chk("basic first draw", log_q[base + 2], 32'h20060805);
    chk("idle holds instruction", instruction_dp, 32'h20060A07);

    base = log_q.size();
    run_vec("erase", vecs[1]);
    chk("erase first draw", log_q[base + 2], 32'h20040805);

    for (int i = 2; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // reset asserted while the second entity's DRAW is in DR_WAIT
    @(negedge clock);
    base = log_q.size();
    erase = 1'b0; count = 5'd3; x_base = 8'd10; y_base = 8'd40; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    w = 0;
    while (log_q.size() - base < 6 && w < 500) begin
      w++;
      @(negedge clock);
    end
    chk("reached DR_ISSUE of entity 1", 32'(log_q.size() - base), 32'd6);
    @(negedge clock);
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    chk("async reset start_dp", 32'(start_dp), 32'd0);
    chk("async reset finished", 32'(finished), 32'd1);
    chk("async reset instruction_dp", instruction_dp, 32'd0);
    chk("async reset drawn_count", 32'(drawn_count), 32'd0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    base = log_q.size();
    run_vec("restart", vecs[0]);
    chk("restart first read", log_q[base], 32'h1000000A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
